uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Byte FIFO placed behind a UART receiver. Each one-cycle i_Rx_DV strobe
//   pushes i_Rx_Byte. The consumer reads the head entry in first-word
//   fall-through style through a valid/ready pair. If a byte arrives while
//   the FIFO is full and nothing is being popped, that byte is dropped and a
//   sticky overrun flag is raised.
//
// Parameters
//   DEPTH   number of byte entries (power of two, >= 2)
//   ADDR_W  log2(DEPTH)
//
// Ports
//   i_Clock          rising-edge clock
//   i_Reset          asynchronous active-high reset
//   i_Rx_DV          one-cycle strobe: i_Rx_Byte holds a received byte
//   i_Rx_Byte[7:0]   received byte
//   o_Valid          head entry available (= ~o_Empty)
//   o_Data[7:0]      head entry; 8'h00 while empty
//   i_Ready          consumer accepts the head entry
//   o_Count          occupancy, 0..DEPTH
//   o_Empty, o_Full  occupancy == 0 / occupancy == DEPTH
//   o_Overrun        sticky: a received byte was dropped
//   i_Clear_Overrun  synchronous clear of o_Overrun (a new drop wins)
//
// Handshake: a pop happens on every rising edge where o_Valid=1 and
// i_Ready=1. o_Valid is derived only from registered state and never looks
// at i_Ready. o_Data stays constant unless a pop occurs, or a push lands in
// an empty FIFO. The receiver side has no backpressure: i_Rx_DV is a strobe,
// and the byte is either accepted or dropped.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              i_Clock,
   input  logic              i_Reset,
   input  logic              i_Rx_DV,
   input  logic [7:0]        i_Rx_Byte,
   output logic              o_Valid,
   output logic [7:0]        o_Data,
   input  logic              i_Ready,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Empty,
   output logic              o_Full,
   output logic              o_Overrun,
   input  logic              i_Clear_Overrun
);

   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [7:0]      r_mem [DEPTH];
   logic [ADDR_W:0] r_wr_ptr;
   logic [ADDR_W:0] r_rd_ptr;
   logic            r_overrun;

   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [ADDR_W:0] w_count;

   // The extra pointer MSB tells full apart from empty when the low bits match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign w_count = r_wr_ptr - r_rd_ptr;

   assign w_pop  = ~w_empty & i_Ready;
   // When full, a pop in the same cycle frees the slot, so the push is accepted.
   assign w_push = i_Rx_DV & (~w_full | w_pop);
   assign w_drop = i_Rx_DV & ~w_push;

   // Pointers wrap naturally modulo 2*DEPTH.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; reset only empties the FIFO through the pointers.
   always_ff @(posedge i_Clock) begin
      if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_Rx_Byte;
   end

   // When a drop and a clear coincide, the drop wins.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (i_Clear_Overrun) begin
         r_overrun <= 1'b0;
      end
   end

   assign o_Valid   = ~w_empty;
   assign o_Data    = w_empty ? 8'h00 : r_mem[r_rd_ptr[ADDR_W-1:0]];
   assign o_Count   = w_count;
   assign o_Empty   = w_empty;
   assign o_Full    = w_full;
   assign o_Overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   // ---------------- clock / reset ----------------
   logic i_Clock = 1'b0;
   always #5 i_Clock = ~i_Clock;

   logic              i_Reset = 1'b1;
   logic              i_Rx_DV = 1'b0;
   logic [7:0]        i_Rx_Byte = 8'h00;
   logic              i_Ready = 1'b0;
   logic              i_Clear_Overrun = 1'b0;
   logic              o_Valid;
   logic [7:0]        o_Data;
   logic [ADDR_W:0]   o_Count;
   logic              o_Empty;
   logic              o_Full;
   logic              o_Overrun;

   uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .i_Clock         (i_Clock),
      .i_Reset         (i_Reset),
      .i_Rx_DV         (i_Rx_DV),
      .i_Rx_Byte       (i_Rx_Byte),
      .o_Valid         (o_Valid),
      .o_Data          (o_Data),
      .i_Ready         (i_Ready),
      .o_Count         (o_Count),
      .o_Empty         (o_Empty),
      .o_Full          (o_Full),
      .o_Overrun       (o_Overrun),
      .i_Clear_Overrun (i_Clear_Overrun)
   );

   // ---------------- scoreboard / reference model ----------------
   logic [7:0] exp_q[$];
   logic       exp_ovr = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Checks every registered-state output against the model.
   task automatic check_state(input string tag);
      check_val({tag, ".count"}, 32'(o_Count), exp_q.size());
      check_val({tag, ".empty"}, 32'(o_Empty), 32'(exp_q.size() == 0));
      check_val({tag, ".full"},  32'(o_Full),  32'(exp_q.size() == DEPTH));
      check_val({tag, ".valid"}, 32'(o_Valid), 32'(exp_q.size() != 0));
      check_val({tag, ".data"},  32'(o_Data),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
      check_val({tag, ".ovr"},   32'(o_Overrun), 32'(exp_ovr));
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge. Drives one cycle of inputs, advances
   // the model by the FIFO rules, then checks outputs 1 ns after the edge.
   task automatic do_cycle(input logic dv, input logic [7:0] b, input logic rdy,
                           input logic clr, input string tag);
      bit pop, push, drop;
      i_Rx_DV = dv;
      i_Rx_Byte = b;
      i_Ready = rdy;
      i_Clear_Overrun = clr;
      pop  = rdy && (exp_q.size() != 0);
      push = dv && ((exp_q.size() < DEPTH) || pop);
      drop = dv && !push;
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(b);
      if (drop) exp_ovr = 1'b1;
      else if (clr) exp_ovr = 1'b0;
      @(posedge i_Clock);
      #1;
      i_Rx_DV = 1'b0;
      i_Ready = 1'b0;
      i_Clear_Overrun = 1'b0;
      check_state(tag);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 2 * DEPTH && exp_q.size() != 0; k++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset state.
      #2;
      check_state("reset");
      @(posedge i_Clock);
      #1;
      i_Reset = 1'b0;
      check_state("post_reset");

      // Single byte.
      do_cycle(1'b1, 8'hA5, 1'b0, 1'b0, "single_push");
      check_val("single_data", 32'(o_Data), 32'hA5);
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "single_pop");
      check_val("single_empty_data", 32'(o_Data), 32'h00);

      // Fill, overrun, drain in order.
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
      check_val("fill_full", 32'(o_Full), 32'd1);
      do_cycle(1'b1, 8'hFF, 1'b0, 1'b0, "overrun");
      check_val("overrun_flag", 32'(o_Overrun), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         check_val("drain_order", 32'(o_Data), 32'(i));
         do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
      end
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, "clear_ovr");

      // Full with simultaneous push and pop: 8'h55 is read out last.
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "fill2");
      do_cycle(1'b1, 8'h55, 1'b1, 1'b0, "full_push_pop");
      check_val("fpp_count", 32'(o_Count), DEPTH);
      check_val("fpp_ovr", 32'(o_Overrun), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "fpp_drain");
      check_val("fpp_last", 32'(o_Data), 32'h55);

      // Overrun clear collision: still one byte in, refill to full.
      for (int i = 0; i < DEPTH - 1; i++) do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "fill3");
      do_cycle(1'b1, 8'hEE, 1'b0, 1'b1, "clr_collide");
      check_val("collide_ovr", 32'(o_Overrun), 32'd1);
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr_alone");
      check_val("clear_ovr", 32'(o_Overrun), 32'd0);
      drain("drain3");

      // Random traffic with wrap-around.
      for (int i = 0; i < 300; i++) begin
         do_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), "random");
         check_val("rand_count_max", 32'(o_Count <= DEPTH), 32'd1);
      end
      drain("drain_rand");

      // Asynchronous reset with count 5 and overrun set.
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, "fill4");
      do_cycle(1'b1, 8'h11, 1'b0, 1'b0, "ovr4");
      for (int i = 0; i < DEPTH - 5; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0, "to_five");
      check_val("pre_reset_count", 32'(o_Count), 32'd5);
      #2;
      i_Reset = 1'b1;
      i_Rx_DV = 1'b1;
      i_Rx_Byte = 8'h77;
      #1;
      exp_q.delete();
      exp_ovr = 1'b0;
      check_val("async_count", 32'(o_Count), 32'd0);
      check_val("async_valid", 32'(o_Valid), 32'd0);
      check_val("async_ovr", 32'(o_Overrun), 32'd0);
      check_state("async_reset");
      @(posedge i_Clock);
      #1;
      check_state("reset_held");
      i_Rx_DV = 1'b0;
      i_Reset = 1'b0;
      do_cycle(1'b1, 8'h3C, 1'b0, 1'b0, "resume");
      drain("drain_end");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
